// File: rtl/algo_4r1w_pkg.sv
// Shared types and constants for the 4r1w algorithmic memory control blocks.
// Holds the init sequencer state encoding and the zero-word parity helper.
package algo_4r1w_pkg;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_WAIT = 2'd1,
        ST_INIT = 2'd2,
        ST_DONE = 2'd3
    } init_state_e;

    localparam int unsigned PHYWDTH2_DEF = 65;
    localparam int unsigned BITSROW2_DEF = 11;

    // Even parity over a data field; wide enough for any supported word.
    function automatic logic even_parity(input logic [255:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/algo_4r1w_init_seq_cnt.sv
// Loadable up-counter with a terminal-count flag.
// Shared by the init sequencer for both the settle delay and the row sweep.
module algo_init_cnt #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/algo_4r1w_init_seq.sv
// Power-up / on-demand init sequencer for the 4r1w memory: zero-fills every
// row of all bank instances, gates ready, and flags accesses while not ready.
//
// state | meaning
// RST   | held in reset
// WAIT  | settle countdown before the sweep
// INIT  | row sweep, one zero write per unstalled cycle
// DONE  | idle, memory ready
module algo_4r1w_init_seq
    import algo_4r1w_pkg::*;
#(
    parameter int unsigned NUMVBNK1  = 4,
    parameter int unsigned NUMVBNK2  = 4,
    parameter int unsigned NUMSROW2  = 2048,
    parameter int unsigned BITSROW2  = BITSROW2_DEF,
    parameter int unsigned PHYWDTH2  = PHYWDTH2_DEF,
    parameter int unsigned RESET_DLY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_stall,
    input  logic                reinit_req,
    output logic                reinit_ack,
    input  logic                write,
    input  logic [3:0]          read,
    output logic                ready,
    output logic                init_vld,
    output logic [BITSROW2-1:0] init_adr,
    output logic [PHYWDTH2-1:0] init_din,
    output logic                busy_err,
    input  logic                busy_clr
);

    localparam int unsigned DLYW = $clog2(RESET_DLY + 1) + 1;
    localparam int unsigned CW   = (BITSROW2 > DLYW) ? BITSROW2 : DLYW;

    localparam logic [CW-1:0]       WAIT_TERM = CW'(RESET_DLY);
    localparam logic [CW-1:0]       ROW_LAST  = CW'(NUMSROW2 - 1);
    localparam logic [CW-1:0]       ROW_NEXT0 = (NUMSROW2 > 1) ? CW'(1) : '0;
    localparam logic [BITSROW2-1:0] ADR_LAST  = BITSROW2'(NUMSROW2 - 1);
    localparam logic                INIT_PAR  = even_parity('0);

    if ((2 ** BITSROW2) < NUMSROW2 || NUMSROW2 == 0 ||
        NUMVBNK1 == 0 || NUMVBNK2 == 0 || PHYWDTH2 < 2) begin : g_bad_param
        $error("algo_4r1w_init_seq: illegal parameter set");
    end

    init_state_e         state_q, state_d;
    logic                ready_q, ready_d;
    logic                vld_q, vld_d;
    logic [BITSROW2-1:0] adr_q, adr_d;
    logic                ack_q, ack_d;
    logic                pend_q, pend_d;
    logic                busy_q, busy_d;

    logic                cnt_load;
    logic [CW-1:0]       cnt_val;
    logic                cnt_inc;
    logic [CW-1:0]       cnt_term;
    logic [CW-1:0]       cnt_q;
    logic                cnt_tc;
    logic                last_written;
    logic                access;

    assign cnt_term     = (state_q == ST_WAIT) ? WAIT_TERM : ROW_LAST;
    assign last_written = vld_q && (adr_q == ADR_LAST);
    assign access       = write || (|read);

    algo_init_cnt #(
        .W (CW)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .inc_i      (cnt_inc),
        .term_i     (cnt_term),
        .cnt_o      (cnt_q),
        .tc_o       (cnt_tc)
    );

    // Outputs are computed for the next cycle so every output is a flop.
    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        vld_d    = 1'b0;
        adr_d    = adr_q;
        ack_d    = 1'b0;
        pend_d   = pend_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_inc  = 1'b0;

        unique case (state_q)
            ST_RST: begin
                state_d  = ST_WAIT;
                adr_d    = '0;
                cnt_load = 1'b1;
            end
            ST_WAIT: begin
                if (cnt_tc) begin
                    state_d  = ST_INIT;
                    adr_d    = '0;
                    cnt_load = 1'b1;
                    if (!init_stall) begin
                        vld_d   = 1'b1;
                        cnt_val = ROW_NEXT0;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_INIT: begin
                if (last_written) begin
                    state_d  = ST_DONE;
                    ready_d  = 1'b1;
                    adr_d    = '0;
                    cnt_load = 1'b1;
                    if (pend_q) begin
                        ack_d  = 1'b1;
                        pend_d = 1'b0;
                    end
                end else begin
                    // Address tracks the pending row even while stalled.
                    adr_d = cnt_q[BITSROW2-1:0];
                    if (!init_stall) begin
                        vld_d = 1'b1;
                        if (cnt_tc) begin
                            cnt_load = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (reinit_req) begin
                    state_d  = ST_WAIT;
                    pend_d   = 1'b1;
                    cnt_load = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // A new violation wins over a same-cycle clear.
    assign busy_d = (access && !ready_q) ? 1'b1 : (busy_clr ? 1'b0 : busy_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RST;
            ready_q <= 1'b0;
            vld_q   <= 1'b0;
            adr_q   <= '0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            vld_q   <= vld_d;
            adr_q   <= adr_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
        end
    end

    assign ready      = ready_q;
    assign init_vld   = vld_q;
    assign init_adr   = adr_q;
    assign reinit_ack = ack_q;
    assign busy_err   = busy_q;
    assign init_din   = {{(PHYWDTH2 - 1){1'b0}}, INIT_PAR};

endmodule

// File: tb/tb_algo_4r1w_init_seq.sv
// Directed bench for algo_4r1w_init_seq: an 8-row instance with a 2-cycle
// settle delay, plus a zero-delay instance sharing the clock and reset.
module tb_algo_4r1w_init_seq;

    localparam int N  = 8;
    localparam int BR = 3;
    localparam int PW = 65;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          init_stall;
    logic          reinit_req;
    logic          reinit_ack;
    logic          write_s;
    logic [3:0]    read_s;
    logic          ready;
    logic          init_vld;
    logic [BR-1:0] init_adr;
    logic [PW-1:0] init_din;
    logic          busy_err;
    logic          busy_clr;

    logic          z_stall;
    logic          z_req;
    logic          z_ack;
    logic          z_write;
    logic [3:0]    z_read;
    logic          z_ready;
    logic          z_vld;
    logic [BR-1:0] z_adr;
    logic [PW-1:0] z_din;
    logic          z_busy;
    logic          z_clr;

    algo_4r1w_init_seq #(
        .NUMVBNK1 (4), .NUMVBNK2 (4), .NUMSROW2 (N), .BITSROW2 (BR),
        .PHYWDTH2 (PW), .RESET_DLY (2)
    ) dut (
        .clk (clk), .rst (rst), .init_stall (init_stall),
        .reinit_req (reinit_req), .reinit_ack (reinit_ack),
        .write (write_s), .read (read_s), .ready (ready),
        .init_vld (init_vld), .init_adr (init_adr), .init_din (init_din),
        .busy_err (busy_err), .busy_clr (busy_clr)
    );

    algo_4r1w_init_seq #(
        .NUMVBNK1 (4), .NUMVBNK2 (4), .NUMSROW2 (N), .BITSROW2 (BR),
        .PHYWDTH2 (PW), .RESET_DLY (0)
    ) dut_z (
        .clk (clk), .rst (rst), .init_stall (z_stall),
        .reinit_req (z_req), .reinit_ack (z_ack),
        .write (z_write), .read (z_read), .ready (z_ready),
        .init_vld (z_vld), .init_adr (z_adr), .init_din (z_din),
        .busy_err (z_busy), .busy_clr (z_clr)
    );

    int ntests = 0;
    int nfail  = 0;
    int cyc    = -100;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        int e_vld, e_adr, e_rdy, e_ack, e_busy;

        rst = 1'b0; init_stall = 1'b0; reinit_req = 1'b0; write_s = 1'b0;
        read_s = 4'b0; busy_clr = 1'b0;
        z_stall = 1'b0; z_req = 1'b0; z_write = 1'b0; z_read = 4'b0; z_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_vld", init_vld, 0);
        check("rst_adr", init_adr, 0);
        check("rst_ack", reinit_ack, 0);
        check("rst_busy", busy_err, 0);
        check("rst_din", init_din, 0);
        check("rst_z_ready", z_ready, 0);

        // Plain sweep, busy monitor, then a re-init sweep with ack.
        rst = 1'b1;
        cyc = -1;
        for (int k = 0; k <= 44; k++) begin
            tick();
            e_vld  = ((k >= 3 && k <= 10) || (k >= 24 && k <= 31)) ? 1 : 0;
            e_adr  = (k >= 3 && k <= 10) ? k - 3 : (k >= 24 && k <= 31) ? k - 24 : 0;
            e_rdy  = ((k >= 11 && k <= 20) || k >= 32) ? 1 : 0;
            e_ack  = (k == 32) ? 1 : 0;
            e_busy = (k >= 6 && k <= 12) ? 1 : 0;
            check("p1_vld", init_vld, e_vld);
            check("p1_adr", init_adr, e_adr);
            check("p1_ready", ready, e_rdy);
            check("p1_ack", reinit_ack, e_ack);
            check("p1_busy", busy_err, e_busy);
            check("p1_din", init_din, 0);
            if (k <= 12) begin
                check("z_vld", z_vld, (k >= 1 && k <= 8) ? 1 : 0);
                check("z_adr", z_adr, (k >= 1 && k <= 8) ? k - 1 : 0);
                check("z_ready", z_ready, (k >= 9) ? 1 : 0);
            end
            read_s     = (k == 5) ? 4'b0010 : (k == 40) ? 4'b1000 : 4'b0000;
            write_s    = (k == 15) ? 1'b1 : 1'b0;
            busy_clr   = (k == 12) ? 1'b1 : 1'b0;
            reinit_req = (k == 20 || k == 44) ? 1'b1 : 1'b0;
        end

        // Re-init started at 44; reset at row 5 must drop the pending ack.
        tick();
        reinit_req = 1'b0;
        check("p3_ready_drop", ready, 0);
        for (int k = 46; k <= 53; k++) tick();
        check("p3_pre_vld", init_vld, 1);
        check("p3_pre_adr", init_adr, 5);
        #2 rst = 1'b0;
        #1;
        check("p3_async_vld", init_vld, 0);
        check("p3_async_ready", ready, 0);
        check("p3_async_adr", init_adr, 0);
        @(posedge clk);
        #1;
        check("p3_held_vld", init_vld, 0);
        rst = 1'b1;
        cyc = -1;
        for (int k = 0; k <= 14; k++) begin
            tick();
            e_vld = (k >= 3 && k <= 10) ? 1 : 0;
            check("p3_vld", init_vld, e_vld);
            check("p3_adr", init_adr, e_vld ? k - 3 : 0);
            check("p3_ready", ready, (k >= 11) ? 1 : 0);
            check("p3_ack", reinit_ack, 0);
        end

        // Stall for three cycles at row 4; a request during INIT is ignored.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        cyc = -1;
        for (int k = 0; k <= 17; k++) begin
            tick();
            e_vld = ((k >= 3 && k <= 6) || (k >= 10 && k <= 13)) ? 1 : 0;
            e_adr = (k >= 3 && k <= 6) ? k - 3 : (k >= 7 && k <= 9) ? 4 :
                    (k >= 10 && k <= 13) ? k - 6 : 0;
            check("p2_vld", init_vld, e_vld);
            check("p2_adr", init_adr, e_adr);
            check("p2_ready", ready, (k >= 14) ? 1 : 0);
            check("p2_ack", reinit_ack, 0);
            init_stall = (k >= 6 && k <= 8) ? 1'b1 : 1'b0;
            reinit_req = (k == 5) ? 1'b1 : 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
